// File: rtl/avr_pkg.sv
// Shared AVR core constants: word widths, two-word opcode masks and fetch state encodings.
package avr_pkg;

  localparam int unsigned size_inst = 16;
  localparam int unsigned size_fm   = 8;

  localparam logic [size_inst-1:0] LDS_STS_MASK   = 16'hFC0F;
  localparam logic [size_inst-1:0] LDS_STS_MATCH  = 16'h9000;
  localparam logic [size_inst-1:0] JMP_CALL_MASK  = 16'hFE0C;
  localparam logic [size_inst-1:0] JMP_CALL_MATCH = 16'h940C;

  typedef enum logic {
    FETCH1 = 1'b0,
    FETCH2 = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_len_dec.sv
// Combinational predecode: flags opcodes that carry a second instruction word.
module inst_len_dec
  import avr_pkg::*;
(
  input  logic [size_inst-1:0] inst,
  output logic                 two_word_c
);

  always_comb begin
    two_word_c = ((inst & LDS_STS_MASK) == LDS_STS_MATCH) ||
                 ((inst & JMP_CALL_MASK) == JMP_CALL_MATCH);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, assembles one/two-word instructions and offers them
// to the decoder over a valid/ready handshake; execute redirects flush the fetch.
module fetch_unit
  import avr_pkg::*;
#(
  parameter logic [size_fm-1:0] RESET_VEC = 8'h00
) (
  input  logic                 clk_if,
  input  logic                 rst_if,
  input  logic                 en_if,
  output logic [size_fm-1:0]   Pc_adress,
  input  logic [size_inst-1:0] In_inst,
  output logic                 Inst_valid,
  input  logic                 Inst_ready,
  output logic [size_inst-1:0] Inst_word0,
  output logic [size_inst-1:0] Inst_word1,
  output logic                 Inst_two,
  output logic [size_fm-1:0]   Pc_cur,
  input  logic                 Br_take,
  input  logic [size_fm-1:0]   Br_target
);

  fetch_state_e         state_q, state_d;
  logic [size_fm-1:0]   pc_q, pc_d;
  logic [size_fm-1:0]   pc_cur_q, pc_cur_d;
  logic [size_inst-1:0] word0_q, word0_d;
  logic [size_inst-1:0] word1_q, word1_d;
  logic                 valid_q, valid_d;
  logic                 two_q, two_d;
  logic                 two_word_c;
  logic                 advance_c;

  inst_len_dec u_len_dec (
    .inst       (In_inst),
    .two_word_c (two_word_c)
  );

  assign advance_c = en_if & (~valid_q | Inst_ready);

  always_ff @(posedge clk_if or negedge rst_if) begin
    if (!rst_if) begin
      state_q  <= FETCH1;
      pc_q     <= RESET_VEC;
      pc_cur_q <= '0;
      word0_q  <= '0;
      word1_q  <= '0;
      valid_q  <= 1'b0;
      two_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_cur_q <= pc_cur_d;
      word0_q  <= word0_d;
      word1_q  <= word1_d;
      valid_q  <= valid_d;
      two_q    <= two_d;
    end
  end

  // Next-state: a redirect overrides everything; otherwise walk FETCH1/FETCH2.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_cur_d = pc_cur_q;
    word0_d  = word0_q;
    word1_d  = word1_q;
    valid_d  = valid_q;
    two_d    = two_q;
    if (en_if && Br_take) begin
      pc_d    = Br_target;
      valid_d = 1'b0;
      state_d = FETCH1;
    end else begin
      unique case (state_q)
        FETCH1: begin
          if (advance_c) begin
            word0_d  = In_inst;
            pc_cur_d = pc_q;
            pc_d     = pc_q + size_fm'(1);
            two_d    = 1'b0;
            word1_d  = '0;
            if (two_word_c) begin
              state_d = FETCH2;
              valid_d = 1'b0;
            end else begin
              valid_d = 1'b1;
            end
          end
        end
        FETCH2: begin
          if (en_if) begin
            word1_d = In_inst;
            pc_d    = pc_q + size_fm'(1);
            valid_d = 1'b1;
            two_d   = 1'b1;
            state_d = FETCH1;
          end
        end
        default: state_d = FETCH1;
      endcase
    end
  end

  assign Pc_adress  = pc_q;
  assign Pc_cur     = pc_cur_q;
  assign Inst_word0 = word0_q;
  assign Inst_word1 = word1_q;
  assign Inst_valid = valid_q;
  assign Inst_two   = two_q;

endmodule
